memory_bus_arbiter: RTL and testbench

Shares the single-port system memory between two requesters: instruction fetch, which is read-only and driven by the program counter/fetch path, and data access, which is read/write and driven by microcode memory operations. Only one access is outstanding at a time. The owner is chosen by round-robin or fixed priority. Memory latency is covered by a programmable wait-state count. The execution driver stalls on the per-requester ready pulses.

---
 rtl/memory_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_memory_bus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// Two-requester arbiter for the single-port system memory: instruction fetch (read-only)
// and microcode data access (read/write), one outstanding access with programmable wait states.
module memory_bus_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 1,
    parameter int FAIR        = 1
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  fetch_request,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_ready,

    input  logic                  data_request,
    input  logic                  data_write_enable,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] data_write_data,
    output logic [DATA_WIDTH-1:0] data_read_data,
    output logic                  data_ready,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_read_data,

    output logic                  busy,
    output logic                  grant_owner
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t     state;
    logic [3:0] wait_count;
    logic       last_owner;
    logic       access_is_write;
    logic       grant_data;
    logic       any_request;

    // Owner select: 1 = data. Under contention, round-robin favours whoever did not go last.
    always_comb begin
        grant_data = 1'b0;
        if (fetch_request && data_request) begin
            grant_data = (FAIR != 0) ? ~last_owner : 1'b1;
        end else begin
            grant_data = data_request;
        end
    end

    assign any_request = fetch_request | data_request;
    assign busy        = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            wait_count       <= '0;
            last_owner       <= 1'b1;
            access_is_write  <= 1'b0;
            grant_owner      <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            fetch_data       <= '0;
            data_read_data   <= '0;
            fetch_ready      <= 1'b0;
            data_ready       <= 1'b0;
        end else begin
            fetch_ready <= 1'b0;
            data_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_request) begin
                        grant_owner <= grant_data;
                        last_owner  <= grant_data;
                        wait_count  <= WAIT_LOAD;
                        state       <= ACCESS;
                        if (grant_data) begin
                            mem_address     <= data_address;
                            access_is_write <= data_write_enable;
                            if (data_write_enable) begin
                                mem_write_data   <= data_write_data;
                                mem_write_enable <= 1'b1;
                            end else begin
                                mem_read_enable <= 1'b1;
                            end
                        end else begin
                            mem_address     <= fetch_address;
                            access_is_write <= 1'b0;
                            mem_read_enable <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_count != 4'd0) begin
                        wait_count <= wait_count - 4'd1;
                    end else begin
                        // Final access cycle: read data is valid now, so capture it for the owner.
                        if (!access_is_write) begin
                            if (grant_owner) begin
                                data_read_data <= mem_read_data;
                            end else begin
                                fetch_data <= mem_read_data;
                            end
                        end
                        mem_read_enable  <= 1'b0;
                        mem_write_enable <= 1'b0;
                        fetch_ready      <= ~grant_owner;
                        data_ready       <= grant_owner;
                        state            <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: two instances (WAIT_STATES=1 round-robin, WAIT_STATES=3 fixed
// priority) checked every cycle against a timeline model, plus directed access scenarios.
module tb_memory_bus_arbiter;

    logic        clock;
    logic        reset;

    logic        fetch_request     [2];
    logic [15:0] fetch_address     [2];
    logic [7:0]  fetch_data        [2];
    logic        fetch_ready       [2];
    logic        data_request      [2];
    logic        data_write_enable [2];
    logic [15:0] data_address      [2];
    logic [7:0]  data_write_data   [2];
    logic [7:0]  data_read_data    [2];
    logic        data_ready        [2];
    logic [15:0] mem_address       [2];
    logic [7:0]  mem_write_data    [2];
    logic        mem_read_enable   [2];
    logic        mem_write_enable  [2];
    logic [7:0]  mem_read_data     [2];
    logic        busy              [2];
    logic        grant_owner       [2];

    logic [7:0]  rom [256];

    int checks   = 0;
    int failures = 0;
    bit monitor_on = 0;

    // timeline model: elapsed cycles since the grant edge, -1 when idle
    int          m_elapsed [2];
    bit          m_last    [2];
    bit          m_owner   [2];
    bit          m_write   [2];
    logic [15:0] m_addr    [2];
    logic [7:0]  m_wdata   [2];
    logic [7:0]  m_fdata   [2];
    logic [7:0]  m_ddata   [2];

    bit prev_busy [2];
    bit grant_log0 [$];
    bit grant_log1 [$];

    memory_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(1), .FAIR(1)) dut_rr (
        .clock(clock), .reset(reset),
        .fetch_request(fetch_request[0]), .fetch_address(fetch_address[0]),
        .fetch_data(fetch_data[0]), .fetch_ready(fetch_ready[0]),
        .data_request(data_request[0]), .data_write_enable(data_write_enable[0]),
        .data_address(data_address[0]), .data_write_data(data_write_data[0]),
        .data_read_data(data_read_data[0]), .data_ready(data_ready[0]),
        .mem_address(mem_address[0]), .mem_write_data(mem_write_data[0]),
        .mem_read_enable(mem_read_enable[0]), .mem_write_enable(mem_write_enable[0]),
        .mem_read_data(mem_read_data[0]),
        .busy(busy[0]), .grant_owner(grant_owner[0])
    );

    memory_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(3), .FAIR(0)) dut_fp (
        .clock(clock), .reset(reset),
        .fetch_request(fetch_request[1]), .fetch_address(fetch_address[1]),
        .fetch_data(fetch_data[1]), .fetch_ready(fetch_ready[1]),
        .data_request(data_request[1]), .data_write_enable(data_write_enable[1]),
        .data_address(data_address[1]), .data_write_data(data_write_data[1]),
        .data_read_data(data_read_data[1]), .data_ready(data_ready[1]),
        .mem_address(mem_address[1]), .mem_write_data(mem_write_data[1]),
        .mem_read_enable(mem_read_enable[1]), .mem_write_enable(mem_write_enable[1]),
        .mem_read_data(mem_read_data[1]),
        .busy(busy[1]), .grant_owner(grant_owner[1])
    );

    assign mem_read_data[0] = rom[mem_address[0][7:0]];
    assign mem_read_data[1] = rom[mem_address[1][7:0]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int wsOf(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit fairOf(input int i);
        return (i == 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelStep(input int i);
        bit both;
        bit pick;
        if (reset) begin
            m_elapsed[i] = -1;
            m_last[i]    = 1'b1;
            m_owner[i]   = 1'b0;
            m_write[i]   = 1'b0;
            m_addr[i]    = '0;
            m_wdata[i]   = '0;
            m_fdata[i]   = '0;
            m_ddata[i]   = '0;
        end else if (m_elapsed[i] < 0) begin
            if (fetch_request[i] || data_request[i]) begin
                both = fetch_request[i] && data_request[i];
                pick = both ? (fairOf(i) ? !m_last[i] : 1'b1) : data_request[i];
                m_owner[i]   = pick;
                m_last[i]    = pick;
                m_write[i]   = pick && data_write_enable[i];
                m_addr[i]    = pick ? data_address[i] : fetch_address[i];
                if (m_write[i]) m_wdata[i] = data_write_data[i];
                m_elapsed[i] = 0;
            end
        end else if (m_elapsed[i] == wsOf(i) + 1) begin
            m_elapsed[i] = -1;
        end else begin
            m_elapsed[i]++;
            if (m_elapsed[i] == wsOf(i) + 1 && !m_write[i]) begin
                if (m_owner[i]) m_ddata[i] = rom[m_addr[i][7:0]];
                else            m_fdata[i] = rom[m_addr[i][7:0]];
            end
        end
    endtask

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) modelStep(i);
    end

    task automatic checkModel(input int i);
        int e;
        bit strobe;
        bit done;
        e      = m_elapsed[i];
        strobe = (e >= 0) && (e <= wsOf(i));
        done   = (e == wsOf(i) + 1);
        checkOutput($sformatf("i%0d.busy", i), busy[i], e >= 0);
        checkOutput($sformatf("i%0d.mem_read_enable", i), mem_read_enable[i], strobe && !m_write[i]);
        checkOutput($sformatf("i%0d.mem_write_enable", i), mem_write_enable[i], strobe && m_write[i]);
        checkOutput($sformatf("i%0d.fetch_ready", i), fetch_ready[i], done && !m_owner[i]);
        checkOutput($sformatf("i%0d.data_ready", i), data_ready[i], done && m_owner[i]);
        checkOutput($sformatf("i%0d.grant_owner", i), grant_owner[i], m_owner[i]);
        checkOutput($sformatf("i%0d.mem_address", i), mem_address[i], m_addr[i]);
        checkOutput($sformatf("i%0d.mem_write_data", i), mem_write_data[i], m_wdata[i]);
        checkOutput($sformatf("i%0d.fetch_data", i), fetch_data[i], m_fdata[i]);
        checkOutput($sformatf("i%0d.data_read_data", i), data_read_data[i], m_ddata[i]);
    endtask

    always @(negedge clock) begin
        if (monitor_on) begin
            for (int i = 0; i < 2; i++) begin
                checkModel(i);
                if (busy[i] === 1'b1 && !prev_busy[i]) begin
                    if (i == 0) grant_log0.push_back(grant_owner[0]);
                    else        grant_log1.push_back(grant_owner[1]);
                end
                prev_busy[i] = (busy[i] === 1'b1);
            end
        end
    end

    // One negedge step of the two protocol-abiding requesters of instance i.
    task automatic driveStep(input int i, input int pf, input int pd);
        if (fetch_request[i]) begin
            if (fetch_ready[i] === 1'b1) fetch_request[i] = 1'b0;
        end else if ($urandom_range(99) < pf) begin
            fetch_request[i] = 1'b1;
            fetch_address[i] = 16'($urandom);
        end
        if (data_request[i]) begin
            if (data_ready[i] === 1'b1) data_request[i] = 1'b0;
        end else if ($urandom_range(99) < pd) begin
            data_request[i]      = 1'b1;
            data_write_enable[i] = 1'($urandom_range(1));
            data_address[i]      = 16'($urandom);
            data_write_data[i]   = 8'($urandom);
        end
    endtask

    task automatic applyStimulus(input int i, input int cycles, input int pf, input int pd);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            driveStep(i, pf, pd);
        end
    endtask

    task automatic drainRequests(input int i);
        bit done;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clock);
            driveStep(i, 0, 0);
            if (!fetch_request[i] && !data_request[i] && busy[i] !== 1'b1) done = 1;
        end
        checkOutput($sformatf("i%0d.drain_done", i), done, 1);
    endtask

    task automatic waitReady(input int i, input bit is_data, output int lat, output int strobes);
        bit got;
        got = 0; lat = 0; strobes = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clock);
            lat++;
            if ((is_data ? data_ready[i] : fetch_ready[i]) === 1'b1) got = 1;
            else if (mem_read_enable[i] === 1'b1 || mem_write_enable[i] === 1'b1) strobes++;
        end
        checkOutput($sformatf("i%0d.ready_seen", i), got, 1);
    endtask

    task automatic runAccess(input int i, input bit is_data, input bit wr, input logic [15:0] addr,
                             input logic [7:0] wdata, output int lat, output int strobes);
        @(negedge clock);
        if (is_data) begin
            data_request[i] = 1'b1; data_write_enable[i] = wr;
            data_address[i] = addr; data_write_data[i] = wdata;
        end else begin
            fetch_request[i] = 1'b1; fetch_address[i] = addr;
        end
        waitReady(i, is_data, lat, strobes);
        if (is_data) data_request[i] = 1'b0;
        else         fetch_request[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int strobes;
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        rom[8'h10] = 8'h3C;
        rom[8'h44] = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            fetch_request[i] = 0; fetch_address[i] = '0;
            data_request[i] = 0; data_write_enable[i] = 0;
            data_address[i] = '0; data_write_data[i] = '0;
            prev_busy[i] = 0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        monitor_on = 1;

        $display("[TB] idle after reset");
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checkOutput("idle.quiet", {busy[0], busy[1], mem_read_enable[0], mem_write_enable[0],
                                       mem_read_enable[1], mem_write_enable[1], fetch_ready[0], data_ready[0]}, 0);
        end

        $display("[TB] single fetch, one wait state");
        runAccess(0, 0, 0, 16'h0010, 8'h00, lat, strobes);
        checkOutput("fetch.latency", lat, 3);
        checkOutput("fetch.strobe_cycles", strobes, 2);
        checkOutput("fetch.data", fetch_data[0], 8'h3C);
        checkOutput("fetch.address", mem_address[0], 16'h0010);

        $display("[TB] single data write");
        runAccess(0, 1, 1, 16'h0200, 8'hA5, lat, strobes);
        checkOutput("write.latency", lat, 3);
        checkOutput("write.strobe_cycles", strobes, 2);
        checkOutput("write.wdata", mem_write_data[0], 8'hA5);
        checkOutput("write.read_data_kept", data_read_data[0], 8'h00);
        checkOutput("write.address", mem_address[0], 16'h0200);

        $display("[TB] round-robin contention");
        grant_log0.delete();
        applyStimulus(0, 15, 100, 100);
        drainRequests(0);
        checkOutput("rr.grant_count_ok", grant_log0.size() >= 4, 1);
        if (grant_log0.size() >= 4) begin
            checkOutput("rr.grant0", grant_log0[0], 0);
            checkOutput("rr.grant1", grant_log0[1], 1);
            checkOutput("rr.grant2", grant_log0[2], 0);
            checkOutput("rr.grant3", grant_log0[3], 1);
        end

        $display("[TB] fixed priority contention");
        grant_log1.delete();
        applyStimulus(1, 16, 100, 100);
        applyStimulus(1, 20, 100, 0);
        drainRequests(1);
        checkOutput("fp.grant_count_ok", grant_log1.size() >= 4, 1);
        if (grant_log1.size() >= 4) begin
            checkOutput("fp.grant0", grant_log1[0], 1);
            checkOutput("fp.grant1", grant_log1[1], 1);
            checkOutput("fp.grant2", grant_log1[2], 1);
            checkOutput("fp.grant3", grant_log1[3], 0);
        end

        $display("[TB] reset during access");
        @(negedge clock);
        fetch_request[1] = 1'b1;
        fetch_address[1] = 16'h0044;
        @(negedge clock);
        @(negedge clock);
        checkOutput("abort.in_access", mem_read_enable[1], 1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort.strobe", mem_read_enable[1], 0);
        checkOutput("abort.busy", busy[1], 0);
        checkOutput("abort.no_ready", fetch_ready[1], 0);
        reset = 1'b0;
        waitReady(1, 0, lat, strobes);
        fetch_request[1] = 1'b0;
        checkOutput("abort.retry_latency", lat, 5);
        checkOutput("abort.retry_strobes", strobes, 4);
        checkOutput("abort.retry_data", fetch_data[1], 8'h5A);

        $display("[TB] random traffic");
        fork
            applyStimulus(0, 600, 40, 40);
            applyStimulus(1, 600, 35, 35);
        join
        fork
            drainRequests(0);
            drainRequests(1);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
